// File: rtl/wb_commit.sv
// Write-back commit stage: GPR file, HI/LO pair and LLbit, each with a
// same-cycle write-to-read bypass. While rst is low, all state and outputs read zero.
module wb_commit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              wb_whilo,
    input  logic              wb_LLbit_we,
    input  logic              wb_LLbit_value,
    input  logic              flush,
    input  logic              re1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              LLbit_o
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] gpr_q [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_d;
    logic              llbit_q;
    logic              llbit_d;
    logic              gpr_we_s;

    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wd,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] val;
        if (!re || (addr == '0)) begin
            val = '0;
        end else if (we && (addr == wd)) begin
            val = wdata;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Next state of HI/LO/LLbit; it is also exactly the bypassed view seen on the outputs.
    always_comb begin
        gpr_we_s = wb_wreg && (wb_wd != '0);
        hi_d     = wb_whilo ? wb_hi : hi_q;
        lo_d     = wb_whilo ? wb_lo : lo_q;
        if (flush) begin
            llbit_d = 1'b0;
        end else if (wb_LLbit_we) begin
            llbit_d = wb_LLbit_value;
        end else begin
            llbit_d = llbit_q;
        end
    end

    // GPR storage; entry 0 is never written, so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (gpr_we_s) begin
            gpr_q[wb_wd] <= wb_wdata;
        end
    end

    // HI/LO and LLbit storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            llbit_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            llbit_q <= llbit_d;
        end
    end

    // Output view with bypass; forced to zero while rst is low.
    always_comb begin
        if (rst) begin
            rdata1  = read_port(re1, raddr1, gpr_q[raddr1], gpr_we_s, wb_wd, wb_wdata);
            rdata2  = read_port(re2, raddr2, gpr_q[raddr2], gpr_we_s, wb_wd, wb_wdata);
            hi_o    = hi_d;
            lo_o    = lo_d;
            LLbit_o = llbit_d;
        end else begin
            rdata1  = '0;
            rdata2  = '0;
            hi_o    = '0;
            lo_o    = '0;
            LLbit_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_wb_commit;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata, wb_hi, wb_lo;
    logic        wb_whilo, wb_LLbit_we, wb_LLbit_value, flush;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2, hi_o, lo_o;
    logic        LLbit_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Architectural model: plain arrays, updated from the commit rules.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;
    logic        m_ll;

    wb_commit #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
        .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value), .flush(flush),
        .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (!rst || !re || a == 5'd0) return 32'd0;
        if (wb_wreg && wb_wd == a) return wb_wdata;
        return m_gpr[a];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] <= 32'd0;
            m_hi <= 32'd0;
            m_lo <= 32'd0;
            m_ll <= 1'b0;
        end else begin
            if (wb_wreg && wb_wd != 5'd0) m_gpr[wb_wd] <= wb_wdata;
            if (wb_whilo) begin
                m_hi <= wb_hi;
                m_lo <= wb_lo;
            end
            if (flush) m_ll <= 1'b0;
            else if (wb_LLbit_we) m_ll <= wb_LLbit_value;
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_rdata1", rdata1, exp_read(re1, raddr1));
            chk("m_rdata2", rdata2, exp_read(re2, raddr2));
            chk("m_hi", hi_o, !rst ? 32'd0 : (wb_whilo ? wb_hi : m_hi));
            chk("m_lo", lo_o, !rst ? 32'd0 : (wb_whilo ? wb_lo : m_lo));
            chk("m_llbit", {31'd0, LLbit_o},
                {31'd0, rst && !flush && (wb_LLbit_we ? wb_LLbit_value : m_ll)});
        end
    end

    task automatic idle();
        wb_wd = 5'd0; wb_wreg = 1'b0; wb_wdata = 32'd0;
        wb_hi = 32'd0; wb_lo = 32'd0; wb_whilo = 1'b0;
        wb_LLbit_we = 1'b0; wb_LLbit_value = 1'b0; flush = 1'b0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        // Reset with every bypass path active: all outputs must stay zero.
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'h1111_2222;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        wb_whilo = 1'b1; wb_hi = 32'h3; wb_lo = 32'h4;
        wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        #3;
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_llbit", {31'd0, LLbit_o}, 32'd0);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        idle();
        rst = 1'b1;
        re1 = 1'b1; raddr1 = 5'd5;
        #2;
        chk("rst_discard", rdata1, 32'd0);

        // Write then read GPR[5].
        next_cycle(); wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEAD_BEEF;
        next_cycle(); re1 = 1'b1; raddr1 = 5'd5;
        #2; chk("gpr5_read", rdata1, 32'hDEAD_BEEF);
        re1 = 1'b0;
        #1; chk("gpr5_re0", rdata1, 32'd0);

        // Writes to entry 0 are ignored, both same cycle and after.
        next_cycle(); wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'h1234_5678; re1 = 1'b1; raddr1 = 5'd0;
        #2; chk("r0_same", rdata1, 32'd0);
        next_cycle(); re1 = 1'b1; raddr1 = 5'd0;
        #2; chk("r0_next", rdata1, 32'd0);

        // Bypass to both ports, then stored value after the edge.
        next_cycle(); wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hA5A5_A5A5;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
        #2; chk("byp_p1", rdata1, 32'hA5A5_A5A5); chk("byp_p2", rdata2, 32'hA5A5_A5A5);
        next_cycle(); re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd7; raddr2 = 5'd7;
        #2; chk("st_p1", rdata1, 32'hA5A5_A5A5); chk("st_p2", rdata2, 32'hA5A5_A5A5);

        // HI/LO bypass then hold.
        next_cycle(); wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h2;
        #2; chk("hi_byp", hi_o, 32'h1); chk("lo_byp", lo_o, 32'h2);
        next_cycle(); wb_hi = 32'hFF; wb_lo = 32'hFF;
        #2; chk("hi_hold", hi_o, 32'h1); chk("lo_hold", lo_o, 32'h2);

        // LLbit set, then flush beats a simultaneous set.
        next_cycle(); wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        #2; chk("ll_byp", {31'd0, LLbit_o}, 32'd1);
        next_cycle();
        #2; chk("ll_store", {31'd0, LLbit_o}, 32'd1);
        next_cycle(); flush = 1'b1; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        #2; chk("ll_flush", {31'd0, LLbit_o}, 32'd0);
        next_cycle();
        #2; chk("ll_flush_st", {31'd0, LLbit_o}, 32'd0);

        // Concurrent commits, then a mid-cycle reset pulse clears everything.
        next_cycle(); wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hFFFF_FFFF;
        wb_whilo = 1'b1; wb_hi = 32'h1; wb_lo = 32'h0; wb_LLbit_we = 1'b1; wb_LLbit_value = 1'b1;
        next_cycle(); re1 = 1'b1; raddr1 = 5'd3;
        #2; chk("g3_st", rdata1, 32'hFFFF_FFFF); chk("hi_st", hi_o, 32'h1);
        chk("ll_st", {31'd0, LLbit_o}, 32'd1);
        #2; rst = 1'b0;
        #1; chk("pulse_rd", rdata1, 32'd0); chk("pulse_hi", hi_o, 32'd0);
        chk("pulse_ll", {31'd0, LLbit_o}, 32'd0);
        #2; rst = 1'b1;
        next_cycle(); re1 = 1'b1; raddr1 = 5'd3;
        #2; chk("g3_after", rdata1, 32'd0); chk("hi_after", hi_o, 32'd0);
        chk("ll_after", {31'd0, LLbit_o}, 32'd0);

        // Randomized traffic with narrow address range for frequent collisions.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) != 0);
            wb_wreg = $urandom_range(0, 1);
            wb_wd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wb_wdata = $urandom;
            wb_whilo = ($urandom_range(0, 3) == 0);
            wb_hi = $urandom; wb_lo = $urandom;
            wb_LLbit_we = $urandom_range(0, 1);
            wb_LLbit_value = $urandom_range(0, 1);
            flush = ($urandom_range(0, 7) == 0);
            re1 = ($urandom_range(0, 7) != 0);
            re2 = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            raddr2 = ($urandom_range(0, 1) == 0) ? raddr1 : 5'($urandom_range(0, 7));
            if (!rst) begin
                #4;
                rst = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
